// File: rtl/module_if_pkg.sv
// Shared constants for the LEGv8 instruction-fetch stage.
// Covers bus widths, the NOP encoding, the default PC increment and the fetch-address alignment helper.
package module_if_pkg;

    localparam int unsigned INST_ADDR_W = 64;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0]      NOP_INST        = 32'hD503201F;
    localparam logic [INST_ADDR_W-1:0] PC_STEP_DEFAULT = 64'd4;
    localparam logic [INST_ADDR_W-1:0] PC_ALIGN_MASK   = 64'h3;

    // Instruction fetches are word aligned, so the low two address bits are forced to zero.
    function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, inst} holding register for the fetch stage.
// Catches an instruction returning from memory while the IF/ID register is stalled.
module if_skid_buffer
    import module_if_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [INST_ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0]      push_inst,
    output logic                   valid,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_W-1:0]      inst
);

    logic                   valid_r;
    logic [INST_ADDR_W-1:0] pc_r;
    logic [INST_W-1:0]      inst_r;

    // Entry storage; a push on the same cycle as a pop refills the entry.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid_r <= 1'b0;
            pc_r    <= {INST_ADDR_W{1'b0}};
            inst_r  <= NOP_INST;
        end else if (push) begin
            valid_r <= 1'b1;
            pc_r    <= push_pc;
            inst_r  <= push_inst;
        end else if (pop) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign inst  = inst_r;

endmodule

// File: rtl/module_if.sv
// Instruction-fetch stage: owns the PC, requests a 1-cycle synchronous instruction memory
// and drives the IF/ID register, using a 1-entry skid buffer to absorb hazard stalls.
module module_if
    import module_if_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] PC_RESET = 64'h0,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_i,
    input  logic                   branch_taken_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0]      imem_inst_i,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o,
    output logic                   id_valid_o
);

    logic [INST_ADDR_W-1:0] pc_r;
    logic                   inflight_r;
    logic [INST_ADDR_W-1:0] inflight_pc_r;
    logic [INST_ADDR_W-1:0] id_pc_r;
    logic [INST_W-1:0]      id_inst_r;
    logic                   id_valid_r;

    logic                   skid_valid_s;
    logic [INST_ADDR_W-1:0] skid_pc_s;
    logic [INST_W-1:0]      skid_inst_s;
    logic                   skid_push_s;
    logic                   skid_pop_s;
    logic                   skid_clear_s;
    logic                   skid_valid_next_s;

    logic                   id_load_s;
    logic                   id_next_valid_s;
    logic [INST_ADDR_W-1:0] id_next_pc_s;
    logic [INST_W-1:0]      id_next_inst_s;
    logic                   issue_s;

    if_skid_buffer u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (skid_clear_s),
        .push      (skid_push_s),
        .pop       (skid_pop_s),
        .push_pc   (inflight_pc_r),
        .push_inst (imem_inst_i),
        .valid     (skid_valid_s),
        .pc        (skid_pc_s),
        .inst      (skid_inst_s)
    );

    // Per-cycle steering of the returning instruction: redirect beats stall beats normal flow.
    always_comb begin
        skid_push_s       = 1'b0;
        skid_pop_s        = 1'b0;
        skid_clear_s      = 1'b0;
        skid_valid_next_s = 1'b0;
        id_load_s         = 1'b0;
        id_next_valid_s   = 1'b0;
        id_next_pc_s      = id_pc_r;
        id_next_inst_s    = NOP_INST;
        if (reset) begin
            skid_clear_s = 1'b1;
        end else if (branch_taken_i) begin
            // Squash everything younger; IF/ID keeps its PC but becomes a bubble.
            skid_clear_s = 1'b1;
            id_load_s    = 1'b1;
        end else if (stall_i) begin
            skid_push_s       = inflight_r;
            skid_valid_next_s = skid_valid_s | inflight_r;
        end else begin
            id_load_s         = 1'b1;
            skid_pop_s        = skid_valid_s;
            skid_push_s       = skid_valid_s & inflight_r;
            skid_valid_next_s = skid_valid_s & inflight_r;
            if (skid_valid_s) begin
                id_next_valid_s = 1'b1;
                id_next_pc_s    = skid_pc_s;
                id_next_inst_s  = skid_inst_s;
            end else if (inflight_r) begin
                id_next_valid_s = 1'b1;
                id_next_pc_s    = inflight_pc_r;
                id_next_inst_s  = imem_inst_i;
            end else begin
                id_next_valid_s = 1'b0;
            end
        end
        issue_s = !reset && !branch_taken_i && !skid_valid_next_s;
    end

    // PC, in-flight tracking and the IF/ID pipeline register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r          <= PC_RESET;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {INST_ADDR_W{1'b0}};
            id_pc_r       <= {INST_ADDR_W{1'b0}};
            id_inst_r     <= NOP_INST;
            id_valid_r    <= 1'b0;
        end else begin
            if (branch_taken_i) begin
                pc_r <= align_pc(branch_target_i);
            end else if (issue_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            if (id_load_s) begin
                id_pc_r    <= id_next_pc_s;
                id_inst_r  <= id_next_inst_s;
                id_valid_r <= id_next_valid_s;
            end
        end
    end

    assign imem_req_o  = issue_s;
    assign imem_addr_o = pc_r;
    assign id_pc_o     = id_pc_r;
    assign id_inst_o   = id_inst_r;
    assign id_valid_o  = id_valid_r;

endmodule

// File: tb/tb_module_if.sv
// Scoreboard bench for module_if: expected IF/ID hand-offs and fetch addresses are queued
// by the stimulus; monitors pop and compare whenever the DUT presents them.
module tb_module_if;

    logic        clock;
    logic        reset;
    logic        stall_i;
    logic        branch_taken_i;
    logic [63:0] branch_target_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic [63:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    logic        w_req;
    logic [63:0] w_addr;
    logic [31:0] w_inst;
    logic [63:0] w_id_pc;
    logic [31:0] w_id_inst;
    logic        w_id_valid;

    int total = 0;
    int bad   = 0;

    logic [95:0] exp_q[$];
    logic [63:0] addr_q[$];
    logic [95:0] e_item;
    logic [63:0] e_addr;

    module_if dut (
        .clock(clock), .reset(reset), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
    );

    module_if #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
        .clock(clock), .reset(reset), .stall_i(1'b0),
        .branch_taken_i(1'b0), .branch_target_i(64'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_inst_i(w_inst),
        .id_pc_o(w_id_pc), .id_inst_o(w_id_inst), .id_valid_o(w_id_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory models: the word returned is the low half of the address.
    always @(posedge clock) begin
        imem_inst_i <= imem_addr_o[31:0];
        w_inst      <= w_addr[31:0];
    end

    function automatic logic [95:0] item(input logic [63:0] pc);
        return {pc, pc[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ID consumes the IF/ID contents on every cycle it is not stalled.
    always @(negedge clock) begin
        #2;
        if (id_valid_o && !stall_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL id_unexpected: got pc %0h want nothing", id_pc_o);
            end else begin
                e_item = exp_q.pop_front();
                if ({id_pc_o, id_inst_o} !== e_item) begin
                    bad++;
                    $display("FAIL id_handoff: got %0h/%0h want %0h/%0h",
                             id_pc_o, id_inst_o, e_item[95:32], e_item[31:0]);
                end
            end
        end
        if (w_req && addr_q.size() != 0) begin
            total++;
            e_addr = addr_q.pop_front();
            if (w_addr !== e_addr) begin
                bad++;
                $display("FAIL wrap_addr: got %0h want %0h", w_addr, e_addr);
            end
        end
    end

    initial begin
        reset = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 64'h0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", {63'd0, id_valid_o}, 64'd0);
        chk("rst_inst", {32'd0, id_inst_o}, 64'hD503201F);
        chk("rst_pc", id_pc_o, 64'd0);
        chk("rst_req", {63'd0, imem_req_o}, 64'd0);
        chk("rst_w_valid", {63'd0, w_id_valid}, 64'd0);
        chk("rst_w_inst", {32'd0, w_id_inst}, 64'hD503201F);
        chk("rst_w_pc", w_id_pc, 64'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(item(64'(4 * i)));
        addr_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        addr_q.push_back(64'h0);
        addr_q.push_back(64'h4);

        // straight-line fetch
        @(negedge clock); reset = 1'b0; #1;
        chk("first_req", {63'd0, imem_req_o}, 64'd1);
        chk("first_addr", imem_addr_o, 64'h0);
        @(negedge clock); #1;
        chk("c2_bubble", {63'd0, id_valid_o}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock); #1;
            chk("seq_valid", {63'd0, id_valid_o}, 64'd1);
            chk("seq_pc", id_pc_o, 64'(4 * i));
        end
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i <= 8; i++) exp_q.push_back(item(64'(4 * i)));
        exp_q.push_back(item(64'h100));
        exp_q.push_back(item(64'h200));
        exp_q.push_back(item(64'h204));
        exp_q.push_back(item(64'h208));
        @(negedge clock); reset = 1'b0;

        // stall while 0x10 sits in ID
        repeat (6) @(negedge clock);
        stall_i = 1'b1; #1;
        chk("stall_pc0", id_pc_o, 64'h10);
        chk("stall_req0", {63'd0, imem_req_o}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            chk("stall_hold", id_pc_o, 64'h10);
            chk("stall_req", {63'd0, imem_req_o}, 64'd0);
        end
        @(negedge clock); stall_i = 1'b0; #1;
        chk("rel_pc", id_pc_o, 64'h10);
        chk("rel_addr", imem_addr_o, 64'h18);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock); #1;
            chk("rel_valid", {63'd0, id_valid_o}, 64'd1);
            chk("rel_seq", id_pc_o, 64'(64'h10 + 4 * i));
        end

        // redirect while 0x24 is in flight
        @(negedge clock); branch_taken_i = 1'b1; branch_target_i = 64'h100; #1;
        chk("br_req", {63'd0, imem_req_o}, 64'd0);
        @(negedge clock); branch_taken_i = 1'b0; #1;
        chk("br_bubble", {63'd0, id_valid_o}, 64'd0);
        chk("br_addr", imem_addr_o, 64'h100);
        chk("br_req1", {63'd0, imem_req_o}, 64'd1);
        @(negedge clock); #1;
        chk("br_bubble2", {63'd0, id_valid_o}, 64'd0);
        @(negedge clock); #1;
        chk("br_target_pc", id_pc_o, 64'h100);

        // redirect with stall asserted and the skid holding an instruction
        @(negedge clock); stall_i = 1'b1; #1;
        chk("skid_fill_req", {63'd0, imem_req_o}, 64'd0);
        @(negedge clock); branch_taken_i = 1'b1; branch_target_i = 64'h203; #1;
        chk("bs_req", {63'd0, imem_req_o}, 64'd0);
        @(negedge clock); branch_taken_i = 1'b0; stall_i = 1'b0; #1;
        chk("bs_bubble", {63'd0, id_valid_o}, 64'd0);
        chk("bs_addr", imem_addr_o, 64'h200);
        chk("bs_req1", {63'd0, imem_req_o}, 64'd1);
        @(negedge clock); #1;
        chk("bs_bubble2", {63'd0, id_valid_o}, 64'd0);
        @(negedge clock); #1;
        chk("bs_pc", id_pc_o, 64'h200);
        @(negedge clock); #1;
        @(negedge clock); #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #3;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
